// File: rtl/mem_stage_ctrl_pkg.sv
// Shared types and constants for the MEM pipeline stage: FSM states, exception
// bit positions, access-size codes and store lane replication.
package mem_stage_ctrl_pkg;

  localparam int EX_W    = 6;
  localparam int EX_ADEL = 4;
  localparam int EX_ADES = 5;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DONE  = 3'd3,
    S_DRAIN = 3'd4
  } state_t;

  // Byte and half stores copy their data into every lane so the slave can pick
  // any lane by address without a shifter.
  function automatic logic [31:0] store_lanes(input logic [1:0] size, input logic [31:0] d);
    case (size)
      SZ_B:    return {4{d[7:0]}};
      SZ_H:    return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_align.sv
// Picks the addressed byte/half out of a 32-bit load response and zero- or
// sign-extends it; words pass through unchanged.
module mem_load_align
  import mem_stage_ctrl_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  addr_lo,
  input  logic [1:0]  size,
  input  logic        sign,
  output logic [31:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    case (addr_lo)
      2'd0:    byte_sel = rdata[7:0];
      2'd1:    byte_sel = rdata[15:8];
      2'd2:    byte_sel = rdata[23:16];
      default: byte_sel = rdata[31:24];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];
    case (size)
      SZ_B:    result = {{24{sign & byte_sel[7]}}, byte_sel};
      SZ_H:    result = {{16{sign & half_sel[15]}}, half_sel};
      default: result = rdata;
    endcase
  end

endmodule

// File: rtl/mem_stage_ctrl.sv
// MEM pipeline stage: one data-SRAM request per load/store, load alignment, and a
// held result for WB. Drains a response orphaned by a flush before accepting again.
module mem_stage_ctrl
  import mem_stage_ctrl_pkg::*;
(
  input  logic            clock,
  input  logic            resetn,
  input  logic            in_valid,
  input  logic [EX_W-1:0] in_ex,
  input  logic [31:0]     in_pc,
  input  logic [4:0]      in_dest,
  input  logic            in_ld,
  input  logic            in_st,
  input  logic [1:0]      in_size,
  input  logic            in_sign,
  input  logic [31:0]     in_addr,
  input  logic [31:0]     in_wdata,
  input  logic            flush,
  output logic            allow_in,
  output logic            data_req,
  output logic            data_wr,
  output logic [1:0]      data_size,
  output logic [31:0]     data_addr,
  output logic [31:0]     data_wdata,
  input  logic            data_addr_ok,
  input  logic            data_data_ok,
  input  logic [31:0]     data_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [EX_W-1:0] out_ex,
  output logic [31:0]     out_pc,
  output logic [4:0]      out_dest,
  output logic [31:0]     out_result,
  output state_t          dbg_state
);

  // Handshakes: upstream transfers when in_valid & allow_in at a rising edge; the
  // request transfers on data_req & data_addr_ok, the response on data_data_ok; WB
  // takes the result on out_valid & out_ready. Request fields hold until addr_ok.

  state_t            state, state_n;
  logic              ld_q, st_q, sign_q;
  logic [1:0]        size_q, size_norm;
  logic [31:0]       addr_q, result_q, pc_q, load_data;
  logic [EX_W-1:0]   ex_q, ex_new;
  logic [4:0]        dest_q;
  logic              misalign, go_mem, accept, ld_done;

  always_comb begin
    size_norm = (in_size == 2'd3) ? SZ_W : in_size;
    misalign  = ((size_norm == SZ_H) & in_addr[0]) |
                ((size_norm == SZ_W) & (in_addr[1:0] != 2'd0));
    ex_new    = in_ex;
    if (in_ld & misalign) ex_new[EX_ADEL] = 1'b1;
    if (in_st & misalign) ex_new[EX_ADES] = 1'b1;
    go_mem    = (in_ld | in_st) & (ex_new == '0);
  end

  always_comb begin
    state_n  = state;
    allow_in = 1'b0;
    case (state)
      S_IDLE: allow_in = ~flush;
      S_REQ: begin
        if (flush)             state_n = data_addr_ok ? S_DRAIN : S_IDLE;
        else if (data_addr_ok) state_n = S_WAIT;
      end
      S_WAIT: begin
        if (data_data_ok) state_n = flush ? S_IDLE : S_DONE;
        else if (flush)   state_n = S_DRAIN;
      end
      S_DONE: begin
        allow_in = ~flush & out_ready;
        if (flush) state_n = S_IDLE;
      end
      S_DRAIN: if (data_data_ok) state_n = S_IDLE;
      default: state_n = S_IDLE;
    endcase
    accept = allow_in & in_valid;
    if (allow_in) state_n = in_valid ? (go_mem ? S_REQ : S_DONE) : S_IDLE;
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= S_IDLE;
    else         state <= state_n;
  end

  assign ld_done = (state == S_WAIT) & data_data_ok & ~flush & ld_q;

  // result_q doubles as store data until the access completes; loads overwrite it.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      ld_q     <= 1'b0;
      st_q     <= 1'b0;
      sign_q   <= 1'b0;
      size_q   <= 2'd0;
      addr_q   <= '0;
      result_q <= '0;
      ex_q     <= '0;
      pc_q     <= '0;
      dest_q   <= '0;
    end else if (accept) begin
      ld_q     <= in_ld;
      st_q     <= in_st;
      sign_q   <= in_sign;
      size_q   <= size_norm;
      addr_q   <= in_addr;
      result_q <= in_wdata;
      ex_q     <= ex_new;
      pc_q     <= in_pc;
      dest_q   <= in_dest;
    end else if (ld_done) begin
      result_q <= load_data;
    end
  end

  mem_load_align u_align (
    .rdata   (data_rdata),
    .addr_lo (addr_q[1:0]),
    .size    (size_q),
    .sign    (sign_q),
    .result  (load_data)
  );

  assign data_req   = (state == S_REQ);
  assign data_wr    = data_req & st_q;
  assign data_size  = data_req ? size_q : 2'd0;
  assign data_addr  = data_req ? addr_q : '0;
  assign data_wdata = data_req ? store_lanes(size_q, result_q) : '0;

  assign out_valid  = (state == S_DONE) & ~flush;
  assign out_ex     = ex_q;
  assign out_pc     = pc_q;
  assign out_dest   = dest_q;
  assign out_result = result_q;
  assign dbg_state  = state;

endmodule
